// File: rtl/down_timer_ctrl_pkg.sv
// Shared definitions for the countdown timer controller.
//   timer_state_e  : controller state encoding (IDLE / RUN / PAUSE)
//   DEFAULT_WIDTH  : default bit width of the count and load values
//   DEFAULT_ECNT_W : default bit width of the expiry event counter
package down_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } timer_state_e;

  localparam int DEFAULT_WIDTH  = 4;
  localparam int DEFAULT_ECNT_W = 4;

endpackage

// File: rtl/down_timer_ctrl_counter.sv
// Loadable WIDTH-bit down counter that saturates at zero.
// Ports:
//   clk, reset : clock (rising edge) and asynchronous active-high reset
//   clr        : force the count to zero (highest priority)
//   load       : load load_val
//   load_val   : value to load
//   en         : decrement by one, unless already zero
//   q          : current count (registered)
//   zero       : high while q == 0
module down_counter_load #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             zero
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = load_val;
    end else if (en && (q_q != '0)) begin
      q_d = q_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign zero = (q_q == '0);

endmodule

// File: rtl/down_timer_ctrl.sv
// Programmable countdown timer controller with pause/resume and auto-reload.
// Ports:
//   clk, reset  : clock (rising edge) and asynchronous active-high reset
//   start       : IDLE -> load and run; PAUSE -> resume
//   stop        : RUN -> pause (or abort in the terminal cycle); PAUSE -> IDLE
//   load_val    : start / reload value
//   auto_reload : at terminal count, reload and keep running when high
//   q           : current count (registered)
//   busy        : high in RUN or PAUSE
//   done        : one-cycle pulse in the cycle q first holds 0 in RUN
//   expire_cnt  : number of done pulses, wrapping
module down_timer_ctrl
  import down_timer_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int ECNT_W = DEFAULT_ECNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              auto_reload,
  output logic [WIDTH-1:0]  q,
  output logic              busy,
  output logic              done,
  output logic [ECNT_W-1:0] expire_cnt
);

  timer_state_e      state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ECNT_W-1:0] expire_cnt_q, expire_cnt_d;

  logic             cnt_clr;
  logic             cnt_load;
  logic             cnt_en;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_zero;

  down_counter_load #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (load_val),
    .en       (cnt_en),
    .q        (cnt_q),
    .zero     (cnt_zero)
  );

  // done is raised on the edge where the count arrives at zero, either by
  // decrementing from 1 or by (re)loading a zero value.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          cnt_load = 1'b1;
          state_d  = ST_RUN;
          done_d   = (load_val == '0);
        end
      end
      ST_RUN: begin
        if (!cnt_zero) begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else begin
            cnt_en = 1'b1;
            done_d = (cnt_q == WIDTH'(1));
          end
        end else begin
          // Terminal cycle: stop wins over auto-reload.
          if (stop) begin
            state_d = ST_IDLE;
          end else if (auto_reload) begin
            cnt_load = 1'b1;
            done_d   = (load_val == '0);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
    busy_d       = (state_d != ST_IDLE);
    expire_cnt_d = expire_cnt_q + {{(ECNT_W-1){1'b0}}, done_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      expire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      expire_cnt_q <= expire_cnt_d;
    end
  end

  assign q          = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign expire_cnt = expire_cnt_q;

endmodule

// File: tb/tb_down_timer_ctrl.sv
// Self-checking bench for down_timer_ctrl: directed scenarios followed by
// random stimulus, all compared against a behavioural timer model.
module tb_down_timer_ctrl;

  localparam int WIDTH  = 4;
  localparam int ECNT_W = 4;
  localparam int QMOD   = 1 << WIDTH;
  localparam int EMOD   = 1 << ECNT_W;

  logic              clk;
  logic              reset;
  logic              start;
  logic              stop;
  logic [WIDTH-1:0]  load_val;
  logic              auto_reload;
  logic [WIDTH-1:0]  q;
  logic              busy;
  logic              done;
  logic [ECNT_W-1:0] expire_cnt;

  down_timer_ctrl #(
    .WIDTH  (WIDTH),
    .ECNT_W (ECNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .load_val    (load_val),
    .auto_reload (auto_reload),
    .q           (q),
    .busy        (busy),
    .done        (done),
    .expire_cnt  (expire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 = idle, 1 = running, 2 = paused.
  int m_mode;
  int m_q;
  int m_done;
  int m_ecnt;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_q    = 0;
    m_done = 0;
    m_ecnt = 0;
  endtask

  task automatic model_step(input int st, input int sp, input int lv, input int ar);
    m_done = 0;
    if (m_mode == 0) begin
      if (st != 0 && sp == 0) begin
        m_q    = lv;
        m_mode = 1;
        m_done = (lv == 0) ? 1 : 0;
      end
    end else if (m_mode == 1) begin
      if (m_q > 0) begin
        if (sp != 0) begin
          m_mode = 2;
        end else begin
          m_q    = m_q - 1;
          m_done = (m_q == 0) ? 1 : 0;
        end
      end else if (sp != 0) begin
        m_mode = 0;
      end else if (ar != 0) begin
        m_q    = lv;
        m_done = (lv == 0) ? 1 : 0;
      end else begin
        m_mode = 0;
      end
    end else begin
      if (sp != 0) begin
        m_mode = 0;
        m_q    = 0;
      end else if (st != 0) begin
        m_mode = 1;
      end
    end
    m_ecnt = (m_ecnt + m_done) % EMOD;
  endtask

  task automatic check_all(input string where);
    check_val({where, ".q"},          int'(q),          m_q % QMOD);
    check_val({where, ".busy"},       int'(busy),       (m_mode != 0) ? 1 : 0);
    check_val({where, ".done"},       int'(done),       m_done);
    check_val({where, ".expire_cnt"}, int'(expire_cnt), m_ecnt);
  endtask

  task automatic cycle(input int st, input int sp, input int lv, input int ar);
    start       = (st != 0);
    stop        = (sp != 0);
    load_val    = WIDTH'(lv);
    auto_reload = (ar != 0);
    @(posedge clk);
    model_step(st, sp, lv, ar);
    #1;
    check_all("cyc");
  endtask

  task automatic do_reset();
    start = 1'b0; stop = 1'b0; auto_reload = 1'b0; load_val = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_all("rst");
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; stop = 1'b0; auto_reload = 1'b0; load_val = '0;
    model_reset();
    #2;
    do_reset();

    // Reset mid-count takes effect before the next clock edge.
    cycle(1, 0, 9, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 9, 0);
    #3;
    reset = 1'b1;
    #1;
    check_val("async_rst.q",          int'(q),          0);
    check_val("async_rst.busy",       int'(busy),       0);
    check_val("async_rst.done",       int'(done),       0);
    check_val("async_rst.expire_cnt", int'(expire_cnt), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // One-shot from 5.
    cycle(1, 0, 5, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 5, 0);
    check_val("oneshot.busy", int'(busy), 0);
    check_val("oneshot.ecnt", int'(expire_cnt), 1);

    // Auto-reload with period 4: 17 pulses wrap the expiry counter to 1.
    do_reset();
    cycle(1, 0, 3, 1);
    for (int i = 0; i < 67; i++) cycle(0, 0, 3, 1);
    check_val("reload.done", int'(done), 1);
    check_val("reload.ecnt", int'(expire_cnt), 1);
    cycle(0, 1, 3, 1);  // stop in the terminal cycle: no reload
    check_val("term_stop.busy", int'(busy), 0);

    // Pause at 5, hold, resume without reload.
    do_reset();
    cycle(1, 0, 8, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 8, 0);
    cycle(0, 1, 8, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 2, 0);
    check_val("pause.q", int'(q), 5);
    check_val("pause.busy", int'(busy), 1);
    cycle(1, 0, 2, 0);
    for (int i = 0; i < 7; i++) cycle(0, 0, 2, 0);

    // start+stop in RUN pauses, then stop in PAUSE aborts with q = 0.
    cycle(1, 0, 6, 0);
    cycle(0, 0, 6, 0);
    cycle(1, 1, 6, 0);
    cycle(0, 1, 6, 0);
    check_val("abort.q", int'(q), 0);

    // Zero load with auto-reload: done every cycle, then drop to IDLE.
    cycle(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    check_val("zero.busy", int'(busy), 0);

    // Random stimulus.
    for (int i = 0; i < 3000; i++) begin
      int st, sp, lv, ar;
      st = ($urandom_range(0, 3) == 0) ? 1 : 0;
      sp = ($urandom_range(0, 9) == 0) ? 1 : 0;
      lv = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, QMOD - 1));
      ar = int'($urandom_range(0, 1));
      cycle(st, sp, lv, ar);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
